// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a built-in baud-tick generator and a write FIFO.
// The producer pushes words at any rate; frames go out back-to-back while words are queued.
//
// Ports:
//   i_clk       system clock, all logic on the rising edge
//   reset       synchronous active-high reset
//   i_data      word to transmit (D_BITS wide), sampled only on the push edge
//   i_wr_en     push i_data into the FIFO this cycle
//   o_full      FIFO holds FIFO_DEPTH words; further pushes are dropped
//   o_count     words queued, not counting the frame currently on the line
//   o_overflow  1-cycle pulse after a push attempted while full
//   o_tx        serial line, idle high
//   o_busy      a frame is in progress
//   o_tx_done   1-cycle pulse during the last cycle of each frame's final stop bit
module uart_tx_fifo #(
  parameter int unsigned clk_speed  = 100_000_000,
  parameter int unsigned baudrate   = 921600,
  parameter int unsigned D_BITS     = 8,
  parameter int unsigned SP_BITS    = 1,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              i_clk,
  input  logic                              reset,
  input  logic [D_BITS-1:0]                 i_data,
  input  logic                              i_wr_en,
  output logic                              o_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
  output logic                              o_overflow,
  output logic                              o_tx,
  output logic                              o_busy,
  output logic                              o_tx_done
);

  localparam int unsigned Div    = clk_speed / baudrate;
  localparam int unsigned CntW   = $clog2(Div);
  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BitW   = $clog2(D_BITS + 1);

  localparam logic [CntW-1:0]   DivLast  = CntW'(Div - 1);
  localparam logic [BitW-1:0]   DataLast = BitW'(D_BITS - 1);
  localparam logic [BitW-1:0]   StopLast = BitW'(SP_BITS - 1);
  localparam logic [CountW-1:0] DepthVal = CountW'(FIFO_DEPTH);
  localparam logic              HasPar   = (PARITY != 0);
  localparam logic              ParOdd   = (PARITY == 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  // FIFO storage and control
  logic [D_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic              full_q, overflow_q;
  logic              push, pop;
  logic [D_BITS-1:0] head;

  // Transmitter state
  state_e            state_q, state_d;
  logic [CntW-1:0]   baud_q, baud_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [D_BITS-1:0] word_q, word_d;
  logic              par_q, par_d;
  logic              baud_tick;
  logic              tx_d, tx_q;
  logic              done_d, done_q;
  logic              busy_q;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign push      = i_wr_en & ~full_q;
  assign head      = mem_q[rd_ptr_q];
  assign baud_tick = (baud_q == DivLast);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CountW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CountW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    word_d  = word_q;
    par_d   = par_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    done_d  = 1'b0;

    if (state_q != StIdle) begin
      baud_d = baud_tick ? '0 : baud_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (baud_tick) begin
          state_d = StData;
        end
      end
      StData: begin
        tx_d = word_q[0];
        if (baud_tick) begin
          word_d = word_q >> 1;
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = HasPar ? StPar : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StPar: begin
        tx_d = par_q;
        if (baud_tick) begin
          bit_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (bit_q == StopLast) begin
            done_d = 1'b1;
            // Chain straight into the next frame when a word is waiting.
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (pop) begin
      word_d = head;
      par_d  = (^head) ^ ParOdd;
      bit_d  = '0;
    end
  end

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      count_q    <= count_d;
      full_q     <= (count_d == DepthVal);
      overflow_q <= i_wr_en & full_q;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      par_q      <= par_d;
      // Line outputs are registered so the pin is glitch-free; they trail the FSM by one cycle.
      tx_q       <= tx_d;
      done_q     <= done_d;
      busy_q     <= (state_q != StIdle);
    end
  end

  assign o_full     = full_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations run in parallel, each compared every cycle
// against a frame-level reference (word queue plus bit-time arithmetic).
module tb_uart_tx_fifo;

  logic clk;
  int unsigned checks = 0;
  int unsigned errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int unsigned DB    = (g == 2) ? 5 : 8;
    localparam int unsigned SPB   = (g == 1) ? 2 : 1;
    localparam int unsigned PAR   = g;
    localparam int unsigned DEPTH = (g == 0) ? 16 : 4;
    localparam int unsigned BAUD  = (g == 2) ? 25_000_000 : 10_000_000;
    localparam int unsigned DIVV  = 100_000_000 / BAUD;
    localparam int unsigned NB    = 1 + DB + ((PAR != 0) ? 1 : 0) + SPB;
    localparam int unsigned FL    = DIVV * NB;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          rst, wr;
    logic [DB-1:0] data;
    logic          full, ovf, tx, busy, tx_done;
    logic [CW-1:0] count;

    uart_tx_fifo #(
      .clk_speed (100_000_000),
      .baudrate  (BAUD),
      .D_BITS    (DB),
      .SP_BITS   (SPB),
      .PARITY    (PAR),
      .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .i_clk     (clk),
      .reset     (rst),
      .i_data    (data),
      .i_wr_en   (wr),
      .o_full    (full),
      .o_count   (count),
      .o_overflow(ovf),
      .o_tx      (tx),
      .o_busy    (busy),
      .o_tx_done (tx_done)
    );

    // Reference: queued words, and the active frame as a list of line bits indexed by
    // elapsed cycles / bit time. Line outputs appear one cycle after the frame timeline.
    int unsigned mq[$];
    bit          fbits[$];
    bit          act;
    int unsigned pos;
    bit          tx_nxt;
    logic        e_tx, e_busy, e_done, e_full, e_ovf;
    int unsigned e_count;
    bit          full_pre, pop_m, fin_m;
    int unsigned w, ones;
    bit          chk_en = 1'b0;
    bit          fin = 1'b0;
    string       pfx;

    always @(posedge clk) begin
      if (rst) begin
        mq.delete();
        act = 1'b0; pos = 0; tx_nxt = 1'b1;
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ovf = 1'b0; e_full = 1'b0; e_count = 0;
      end else begin
        full_pre = (mq.size() == DEPTH);
        e_tx     = tx_nxt;
        e_busy   = act;
        e_ovf    = wr && full_pre;
        fin_m    = 1'b0;
        pop_m    = 1'b0;
        if (act) begin
          pos++;
          if (pos == FL) begin
            fin_m = 1'b1;
            act   = 1'b0;
          end
        end
        if (!act && mq.size() != 0) pop_m = 1'b1;
        if (pop_m) begin
          w = mq.pop_front();
          ones = $countones(w);
          fbits.delete();
          fbits.push_back(1'b0);
          for (int i = 0; i < DB; i++) fbits.push_back(((w >> i) & 1) != 0);
          if (PAR == 1) fbits.push_back((ones % 2) == 0);
          if (PAR == 2) fbits.push_back((ones % 2) == 1);
          for (int i = 0; i < SPB; i++) fbits.push_back(1'b1);
          act = 1'b1;
          pos = 0;
        end
        if (wr && !full_pre) mq.push_back(32'(data));
        e_done  = fin_m;
        e_count = mq.size();
        e_full  = (mq.size() == DEPTH);
        tx_nxt  = act ? fbits[pos / DIVV] : 1'b1;
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check({pfx, "tx"}, tx, e_tx);
        check({pfx, "busy"}, busy, e_busy);
        check({pfx, "done"}, tx_done, e_done);
        check({pfx, "count"}, count, e_count);
        check({pfx, "full"}, full, e_full);
        check({pfx, "ovf"}, ovf, e_ovf);
      end
    end

    task automatic drive(input bit we, input int unsigned v);
      @(negedge clk);
      wr   = we;
      data = DB'(v);
    endtask

    task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        drive(1'b0, 0);
        if (!act && mq.size() == 0) begin
          ok = 1'b1;
          break;
        end
      end
      check({pfx, "idle_reached"}, ok, 1);
      drive(1'b0, 0);
      drive(1'b0, 0);
    endtask

    task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      wr  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check({pfx, "rst_tx"}, tx, 1);
      check({pfx, "rst_busy"}, busy, 0);
      check({pfx, "rst_done"}, tx_done, 0);
      check({pfx, "rst_count"}, count, 0);
      check({pfx, "rst_full"}, full, 0);
      check({pfx, "rst_ovf"}, ovf, 0);
    endtask

    initial begin
      bit seen;
      pfx  = $sformatf("g%0d_", g);
      rst  = 1'b1;
      wr   = 1'b0;
      data = '0;
      @(negedge clk);
      chk_en = 1'b1;
      do_reset();

      // Single frame: A5 on the 8N1 config, 03 on the parity configs.
      drive(1'b1, (g == 0) ? 32'hA5 : 32'h03);
      wait_idle();

      // Back-to-back burst of four words.
      for (int i = 0; i < 4; i++) drive(1'b1, $urandom);
      wait_idle();

      // Overrun the FIFO with consecutive pushes.
      for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, $urandom);
      wait_idle();

      // Reset in the middle of the data bits of an all-zero word.
      drive(1'b1, 0);
      for (int i = 0; i < 3 * DIVV + 2; i++) drive(1'b0, 0);
      do_reset();
      drive(1'b1, $urandom);
      wait_idle();

      // Push of all ones while full, on the same edge as a frame-end pop.
      for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, $urandom);
      seen = 1'b0;
      for (int i = 0; i < 3 * FL; i++) begin
        drive(1'b0, 0);
        if (act && pos == FL - 1 && mq.size() == DEPTH) begin
          seen = 1'b1;
          break;
        end
      end
      check({pfx, "popfull_seen"}, seen, 1);
      wr   = 1'b1;
      data = '1;
      drive(1'b0, 0);
      check({pfx, "popfull_ovf"}, ovf, 1);
      check({pfx, "popfull_count"}, count, DEPTH - 1);
      check({pfx, "popfull_full"}, full, 0);
      wait_idle();

      // Random traffic.
      for (int i = 0; i < 800; i++) drive($urandom_range(0, 15) == 0, $urandom);
      wait_idle();

      fin = 1'b1;
    end
  end

  initial begin
    bit all_fin = 1'b0;
    for (int i = 0; i < 60000; i++) begin
      @(negedge clk);
      if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) begin
        all_fin = 1'b1;
        break;
      end
    end
    check("all_finished", all_fin, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
